// File: rtl/ad_clk_div_mux.sv
// ad_clk_div_mux: ADC sample clock generator. Divides the system clock by one of NUM_SRC
// programmable half-periods, chosen with sel, and produces a registered 50% duty clock.
// Ratio changes and stops take effect only at period boundaries, so no runt pulse is emitted.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   en         run request for the ADC clock
//   sel        requested ratio index (values >= NUM_SRC select NUM_SRC-1)
//   half_per   packed half-periods in clk cycles, entry i at [i*DIV_W +: DIV_W] (0 acts as 1)
//   ad_clk_fin divided ADC clock, registered
//   rise_stb   one-cycle pulse coincident with each 0->1 of ad_clk_fin
//   active_sel ratio index currently driving ad_clk_fin
//   switching  high while a requested ratio is pending and the clock is running
//   rise_cnt   count of ad_clk_fin rising edges since reset, wraps silently

module ad_clk_div_mux #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*DIV_W-1:0] half_per,
  output logic                     ad_clk_fin,
  output logic                     rise_stb,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     switching,
  output logic [CNT_W-1:0]         rise_cnt
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] h_q;

  logic [SEL_W-1:0] sel_idx;
  logic [DIV_W-1:0] half_sel;
  logic [DIV_W-1:0] h_eff;
  logic             cnt_zero;
  logic             period_start;
  logic             idle_next;
  logic [SEL_W-1:0] active_sel_d;
  logic             switching_d;

  // Out-of-range requests fall back to the last implemented ratio.
  always_comb begin
    sel_idx = sel;
    if (32'(sel) >= NUM_SRC) begin
      sel_idx = SEL_W'(NUM_SRC - 1);
    end
  end

  assign half_sel = half_per[32'(sel_idx) * DIV_W +: DIV_W];
  assign h_eff    = (half_sel == '0) ? DIV_W'(1) : half_sel;
  assign cnt_zero = (cnt_q == '0);

  // A new period starts from IDLE or at the last LOW cycle; that is the only point where
  // sel and half_per are sampled.
  always_comb begin
    period_start = en && ((state_q == StIdle) || ((state_q == StLow) && cnt_zero));
    idle_next    = !en && ((state_q == StIdle) || ((state_q == StLow) && cnt_zero));
    active_sel_d = period_start ? sel_idx : active_sel;
    // Evaluated against next-state values so the flag drops in the same cycle active_sel moves.
    switching_d  = !idle_next && (sel_idx != active_sel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      h_q        <= '0;
      ad_clk_fin <= 1'b0;
      rise_stb   <= 1'b0;
      active_sel <= '0;
      switching  <= 1'b0;
      rise_cnt   <= '0;
    end else begin
      rise_stb   <= period_start;
      active_sel <= active_sel_d;
      switching  <= switching_d;
      if (period_start) begin
        state_q    <= StHigh;
        h_q        <= h_eff;
        cnt_q      <= h_eff - DIV_W'(1);
        ad_clk_fin <= 1'b1;
        rise_cnt   <= rise_cnt + CNT_W'(1);
      end else begin
        case (state_q)
          StIdle: begin
            ad_clk_fin <= 1'b0;
          end
          StHigh: begin
            if (cnt_zero) begin
              ad_clk_fin <= 1'b0;
              cnt_q      <= h_q - DIV_W'(1);
              state_q    <= StLow;
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end
          StLow: begin
            // cnt_zero here implies en=0, otherwise period_start would have fired.
            if (cnt_zero) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end
          default: begin
            state_q    <= StIdle;
            ad_clk_fin <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad_clk_div_mux.sv
module tb_ad_clk_div_mux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [63:0] half_per;

  logic        fin, stb, sw;
  logic [1:0]  asel;
  logic [15:0] rcnt;

  logic        fin4, stb4, sw4;
  logic [1:0]  asel4;
  logic [3:0]  rcnt4;

  int n_tests;
  int n_fail;

  ad_clk_div_mux u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sel        (sel),
    .half_per   (half_per),
    .ad_clk_fin (fin),
    .rise_stb   (stb),
    .active_sel (asel),
    .switching  (sw),
    .rise_cnt   (rcnt)
  );

  // Narrow-counter copy for the wrap check; shares all inputs.
  ad_clk_div_mux #(.CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sel        (sel),
    .half_per   (half_per),
    .ad_clk_fin (fin4),
    .rise_stb   (stb4),
    .active_sel (asel4),
    .switching  (sw4),
    .rise_cnt   (rcnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    sel   = 2'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en    = 1'b0;
    sel   = 2'd0;
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({fin, stb, sw, asel, rcnt} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got fin=%0b stb=%0b sw=%0b asel=%0d cnt=%0d exp all 0",
               fin, stb, sw, asel, rcnt);
    end
    n_tests++;
    if (rcnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt4 got %0d exp 0", rcnt4);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if (fin !== 1'b0 || stb !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle i=%0d got fin=%0b stb=%0b exp 0 0", i, fin, stb);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    sel = 2'd0;
    en  = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      logic exp_fin, exp_stb;
      int   exp_cnt;
      tick();
      exp_fin = ((i - 1) % 6) < 3;
      exp_stb = ((i - 1) % 6) == 0;
      exp_cnt = (i - 1) / 6 + 1;
      n_tests++;
      if (fin !== exp_fin || stb !== exp_stb || rcnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL basic i=%0d got fin=%0b stb=%0b cnt=%0d exp fin=%0b stb=%0b cnt=%0d",
                 i, fin, stb, rcnt, exp_fin, exp_stb, exp_cnt);
      end
    end
  endtask

  task automatic test_switch();
    do_reset();
    sel = 2'd0;
    en  = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      logic       exp_fin, exp_stb, exp_sw;
      logic [1:0] exp_asel;
      tick();
      exp_fin  = (i <= 3) || (i >= 7 && i <= 11) || (i == 17);
      exp_stb  = (i == 1) || (i == 7) || (i == 17);
      exp_sw   = (i >= 3) && (i <= 6);
      exp_asel = (i >= 7) ? 2'd1 : 2'd0;
      n_tests++;
      if (fin !== exp_fin || stb !== exp_stb || sw !== exp_sw || asel !== exp_asel) begin
        n_fail++;
        $display("FAIL switch i=%0d got fin=%0b stb=%0b sw=%0b asel=%0d exp %0b %0b %0b %0d",
                 i, fin, stb, sw, asel, exp_fin, exp_stb, exp_sw, exp_asel);
      end
      if (i == 2) sel = 2'd1;
    end
  endtask

  task automatic test_unity();
    do_reset();
    sel = 2'd2;
    en  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic exp_t;
      tick();
      exp_t = (i % 2) == 1;
      n_tests++;
      if (fin !== exp_t || stb !== exp_t || asel !== 2'd2) begin
        n_fail++;
        $display("FAIL unity i=%0d got fin=%0b stb=%0b asel=%0d exp fin=%0b stb=%0b asel=2",
                 i, fin, stb, asel, exp_t, exp_t);
      end
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    sel = 2'd3;
    en  = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      logic exp_fin, exp_stb;
      tick();
      exp_fin = (i <= 4);
      exp_stb = (i == 1);
      n_tests++;
      if (fin !== exp_fin || stb !== exp_stb || rcnt !== 16'd1 || asel !== 2'd3 || sw !== 1'b0)
      begin
        n_fail++;
        $display("FAIL en_drop i=%0d got fin=%0b stb=%0b cnt=%0d asel=%0d sw=%0b exp %0b %0b 1 3 0",
                 i, fin, stb, rcnt, asel, sw, exp_fin, exp_stb);
      end
      if (i == 1) en = 1'b0;
      // sel moves exactly as the stop boundary is taken: stop must win.
      if (i == 8) sel = 2'd1;
    end
  endtask

  task automatic test_reenable();
    do_reset();
    sel = 2'd0;
    en  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      logic exp_fin, exp_stb;
      int   exp_cnt;
      tick();
      exp_fin = ((i - 1) % 6) < 3;
      exp_stb = (i == 1) || (i == 7);
      exp_cnt = (i >= 7) ? 2 : 1;
      n_tests++;
      if (fin !== exp_fin || stb !== exp_stb || rcnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL reenable i=%0d got fin=%0b stb=%0b cnt=%0d exp fin=%0b stb=%0b cnt=%0d",
                 i, fin, stb, rcnt, exp_fin, exp_stb, exp_cnt);
      end
      if (i == 1) en = 1'b0;
      if (i == 4) en = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sel = 2'd0;
    en  = 1'b1;
    tick();
    tick();
    n_tests++;
    if (fin !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre got fin=%0b exp 1", fin);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (fin !== 1'b0 || rcnt !== 16'd0 || stb !== 1'b0 || asel !== 2'd0 || rcnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_now got fin=%0b cnt=%0d stb=%0b asel=%0d cnt4=%0d exp 0 0 0 0 0",
               fin, rcnt, stb, asel, rcnt4);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      logic exp_fin, exp_stb;
      int   exp_cnt;
      tick();
      exp_fin = ((i - 1) % 6) < 3;
      exp_stb = ((i - 1) % 6) == 0;
      exp_cnt = (i >= 7) ? 2 : 1;
      n_tests++;
      if (fin !== exp_fin || stb !== exp_stb || rcnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL areset_post i=%0d got fin=%0b stb=%0b cnt=%0d exp fin=%0b stb=%0b cnt=%0d",
                 i, fin, stb, rcnt, exp_fin, exp_stb, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sel = 2'd2;
    en  = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      int exp_c;
      tick();
      if ((i % 2) == 1) begin
        exp_c = ((i + 1) / 2) % 16;
        n_tests++;
        if (rcnt4 !== 4'(exp_c) || stb4 !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap i=%0d got cnt4=%0d stb4=%0b exp cnt4=%0d stb4=1",
                   i, rcnt4, stb4, exp_c);
        end
      end
    end
    n_tests++;
    if (rcnt !== 16'd17) begin
      n_fail++;
      $display("FAIL wrap_wide got %0d exp 17", rcnt);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    sel      = 2'd0;
    // entry3=4, entry2=0 (acts as 1), entry1=5, entry0=3
    half_per = {16'd4, 16'd0, 16'd5, 16'd3};
    test_reset();
    test_basic();
    test_switch();
    test_unity();
    test_en_drop();
    test_reenable();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
